// File: rtl/x_mult_pkg.sv
// Shared constants and width helpers for the multiplier delay line.
// DLY_DEPTH_DEFAULT : default number of delay stages.
// tap_width()       : width of the tap select for a given depth (minimum 1).
// cnt_width()       : width of an occupancy counter that must reach depth.
package x_mult_pkg;

  localparam int unsigned DLY_DEPTH_DEFAULT = 3;

  function automatic int unsigned tap_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/x_mult_dly_stage.sv
// One valid-tagged register stage of the multiplier delay line.
// Ports:
//   clk       rising-edge clock
//   clrn      asynchronous active-low reset
//   ena       advance enable (0 = hold)
//   flush     synchronous clear, overrides ena
//   in_valid  / in_data   word from the previous stage (or line input)
//   out_valid / out_data  registered word; data is 0 whenever valid is 0
module x_mult_dly_stage #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ena,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ena) begin
      out_valid <= in_valid;
      out_data  <= in_valid ? in_data : '0;
    end
  end

endmodule

// File: rtl/x_mult_delayline.sv
// Valid-tagged delay line for the iterative multiplier datapath.
// Delays a WIDTH-bit word by tap_sel+1 enabled cycles (1..DEPTH).
// Ports:
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   ena        advance enable (0 = stall, all state held)
//   flush      synchronous clear of every stage, overrides ena
//   in_valid   input word is valid
//   in_data    input word
//   tap_sel    output tap; values past DEPTH-1 clamp to the last stage
//   out_valid  valid tag of the selected stage
//   out_data   data of the selected stage, 0 when out_valid is 0
//   busy       any stage holds a valid entry
//   count      number of valid entries across all stages
module x_mult_delayline
  import x_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = DLY_DEPTH_DEFAULT,
  parameter int unsigned TAPW  = tap_width(DEPTH),
  parameter int unsigned CNTW  = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ena,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAPW-1:0]  tap_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNTW-1:0]  count
);

  // Index 0 is the line input; index i+1 is the output of stage i.
  logic [DEPTH:0]   chain_vld;
  logic [WIDTH-1:0] chain_data [DEPTH+1];
  logic [CNTW-1:0]  count_q;
  int unsigned      sel;

  assign chain_vld[0]  = in_valid;
  assign chain_data[0] = in_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    x_mult_dly_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .clrn     (clrn),
      .ena      (ena),
      .flush    (flush),
      .in_valid (chain_vld[i]),
      .in_data  (chain_data[i]),
      .out_valid(chain_vld[i+1]),
      .out_data (chain_data[i+1])
    );
  end

  // A full line always drops an entry when one enters, so the modular
  // add-then-subtract never leaves the range 0..DEPTH.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (ena) begin
      count_q <= count_q + CNTW'(in_valid) - CNTW'(chain_vld[DEPTH]);
    end
  end

  always_comb begin
    sel = (32'(tap_sel) < DEPTH - 1) ? 32'(tap_sel) : DEPTH - 1;
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i == sel) begin
        out_valid = chain_vld[i+1];
        out_data  = chain_vld[i+1] ? chain_data[i+1] : '0;
      end
    end
  end

  assign count = count_q;
  assign busy  = (count_q != '0);

endmodule

// File: tb/tb_x_mult_delayline.sv
// Self-checking bench for x_mult_delayline: a DEPTH=4 instance driven
// against a latency scoreboard plus directed checks, and a DEPTH=3
// instance for the tap-clamp case. Both share clock, reset and inputs.
module tb_x_mult_delayline;

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } sb_ent_t;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ena;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;

  logic [1:0] tap4;
  logic       out_valid4;
  logic [7:0] out_data4;
  logic       busy4;
  logic [2:0] count4;

  logic [1:0] tap3;
  logic       out_valid3;
  logic [7:0] out_data3;
  logic       busy3;
  logic [1:0] count3;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  bit          sb_on    = 1'b0;
  sb_ent_t     sb_q[$];

  always #5 clk = ~clk;

  x_mult_delayline #(
    .WIDTH(8),
    .DEPTH(4)
  ) u_dut4 (
    .clk      (clk),
    .clrn     (clrn),
    .ena      (ena),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .tap_sel  (tap4),
    .out_valid(out_valid4),
    .out_data (out_data4),
    .busy     (busy4),
    .count    (count4)
  );

  x_mult_delayline #(
    .WIDTH(8),
    .DEPTH(3)
  ) u_dut3 (
    .clk      (clk),
    .clrn     (clrn),
    .ena      (ena),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .tap_sel  (tap3),
    .out_valid(out_valid3),
    .out_data (out_data3),
    .busy     (busy3),
    .count    (count3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    logic       cap;
    logic [7:0] d;
    sb_ent_t    ent;
    cap = clrn && !flush && ena && in_valid;
    d   = in_data;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_on) begin
      if (cap) sb_q.push_back('{data: d, due: cyc + 32'(tap4)});
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        ent = sb_q.pop_front();
        chk("sb_valid", 32'(out_valid4), 32'd1);
        chk("sb_data", 32'(out_data4), 32'(ent.data));
      end else begin
        chk("sb_bubble_valid", 32'(out_valid4), 32'd0);
        chk("sb_bubble_data", 32'(out_data4), 32'd0);
      end
    end
  endtask

  initial begin
    clrn = 1'b0; ena = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    tap4 = '0; tap3 = '0;
    #2;
    chk("rst_valid4", 32'(out_valid4), 32'd0);
    chk("rst_data4", 32'(out_data4), 32'd0);
    chk("rst_count4", 32'(count4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_count3", 32'(count3), 32'd0);
    step();
    step();
    #2 clrn = 1'b1;

    // Basic delay at tap 2
    tap4 = 2'd2; ena = 1'b1; sb_on = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA1; step();
    in_data = 8'hB2; step();
    in_data = 8'hC3; step();
    chk("basic_count_peak", 32'(count4), 32'd3);
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 4; i++) step();
    chk("basic_count_drained", 32'(count4), 32'd0);
    chk("basic_busy_drained", 32'(busy4), 32'd0);
    chk("basic_sb_empty", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;

    // Stall at tap 0
    tap4 = 2'd0;
    in_valid = 1'b1; in_data = 8'h55; step();
    chk("stall_first", 32'(out_data4), 32'h55);
    ena = 1'b0; in_data = 8'h66;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_data", 32'(out_data4), 32'h55);
      chk("stall_hold_count", 32'(count4), 32'd1);
    end
    ena = 1'b1; in_valid = 1'b0; in_data = '0;
    step();
    chk("stall_resume_tap0", 32'(out_valid4), 32'd0);
    tap4 = 2'd1; #1;
    chk("stall_resume_tap1", 32'(out_data4), 32'h55);
    chk("stall_resume_count", 32'(count4), 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("stall_66_not_captured", 32'(count4), 32'd0);

    // Flush overrides ena
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 * (i + 1)); step();
    end
    chk("flush_pre_count", 32'(count4), 32'd4);
    tap4 = 2'd3; #1;
    chk("flush_pre_tap3", 32'(out_data4), 32'h11);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    step();
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
    chk("flush_count", 32'(count4), 32'd0);
    chk("flush_busy", 32'(busy4), 32'd0);
    for (int t = 0; t < 4; t++) begin
      tap4 = 2'(t); #1;
      chk("flush_tap_valid", 32'(out_valid4), 32'd0);
      chk("flush_tap_data", 32'(out_data4), 32'd0);
    end
    step();
    chk("flush_77_not_captured", 32'(count4), 32'd0);

    // Full steady stream at tap 3
    tap4 = 2'd3; sb_on = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      in_data = 8'(i * 7 + 3);
      step();
      chk("stream_count", 32'(count4), (i < 4) ? 32'(i) : 32'd4);
    end
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 4; i++) step();
    chk("stream_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("stream_count_drained", 32'(count4), 32'd0);
    sb_on = 1'b0;

    // Tap change and clamp on DEPTH=3
    in_valid = 1'b1;
    in_data = 8'h30; step();
    in_data = 8'h20; step();
    in_data = 8'h10; step();
    ena = 1'b0; in_valid = 1'b0; in_data = '0;
    chk("tap_count3", 32'(count3), 32'd3);
    tap3 = 2'd0; #1;
    chk("tap3_sel0", 32'(out_data3), 32'h10);
    tap3 = 2'd2; #1;
    chk("tap3_sel2", 32'(out_data3), 32'h30);
    tap3 = 2'd1; #1;
    chk("tap3_sel1", 32'(out_data3), 32'h20);
    tap3 = 2'd3; #1;
    chk("tap3_clamp_valid", 32'(out_valid3), 32'd1);
    chk("tap3_clamp_data", 32'(out_data3), 32'h30);

    // Asynchronous reset mid-stream
    tap4 = 2'd2; #1;
    chk("rstmid_pre_count", 32'(count4), 32'd3);
    chk("rstmid_pre_data", 32'(out_data4), 32'h30);
    clrn = 1'b0; #1;
    chk("rstmid_valid", 32'(out_valid4), 32'd0);
    chk("rstmid_data", 32'(out_data4), 32'd0);
    chk("rstmid_count", 32'(count4), 32'd0);
    chk("rstmid_busy", 32'(busy4), 32'd0);
    chk("rstmid_valid3", 32'(out_valid3), 32'd0);
    #1 clrn = 1'b1;
    tap4 = 2'd0; ena = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    chk("rstmid_restart_data", 32'(out_data4), 32'h5A);
    chk("rstmid_restart_count", 32'(count4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/x_mult_delayline.md
Name: x_mult_delayline

Overview:
Parametrised, valid-tagged delay line for the iterative multiplier datapath; successor to the fixed two-stage single-bit shift register. Delays a WIDTH-bit word by a run-time selectable number of enabled cycles (1..DEPTH). Adds a per-stage valid tag, stall (ena), synchronous flush and an occupancy count. Sits between the operand/partial-product registers and the multiplier control FSM, which uses busy/count to know when the pipe has drained.

Parameters:
WIDTH, 1, data width in bits per stage (>=1)
DEPTH, 3, number of stages (>=1); maximum delay in enabled cycles
TAPW, $clog2(DEPTH) (min 1), width of tap_sel
CNTW, $clog2(DEPTH+1), width of count

Ports:
clk  input  1  clock; all state updates on rising edge
clrn  input  1  asynchronous active-low reset (one clock, async assert, active-low; no other reset)
ena  input  1  advance enable; 0 = stall, all state held
flush  input  1  synchronous clear of all stages; overrides ena
in_valid  input  1  input word is valid
in_data  input  WIDTH  input word
tap_sel  input  TAPW  output tap; delay = tap_sel+1 enabled cycles
out_valid  output  1  valid tag of selected stage
out_data  output  WIDTH  data of selected stage, 0 when out_valid=0
busy  output  1  1 when any stage holds a valid entry
count  output  CNTW  number of valid entries across all DEPTH stages

Behaviour:
- State: stage_data[0..DEPTH-1] (WIDTH each), stage_vld[0..DEPTH-1], count register.
- Reset (clrn=0, asynchronous, immediate): all stage_data=0, stage_vld=0, count=0 -> out_valid=0, out_data=0, busy=0, count=0. Reset dominates flush/ena. Reset mid-operation discards all in-flight entries; first edge after deassertion behaves as from empty.
- Priority at rising edge: flush > ena > hold.
- flush=1: all stage_vld<=0, all stage_data<=0, count<=0; in_valid/in_data ignored that cycle (input not captured).
- flush=0, ena=1: stage[0]<={in_valid, in_valid ? in_data : 0}; stage[i]<=stage[i-1] for i=1..DEPTH-1; entry in stage[DEPTH-1] is dropped. count<=count + in_valid - stage_vld[DEPTH-1] (simultaneous enter+exit leaves count unchanged; never under/overflows, max = DEPTH).
- flush=0, ena=0: everything held; in_valid ignored (no capture, no backpressure signal; caller must hold the word).
- Output is combinational from stage registers: sel = min(tap_sel, DEPTH-1) (out-of-range clamps to last stage); out_valid=stage_vld[sel]; out_data=stage_vld[sel] ? stage_data[sel] : 0.
- Latency: word with in_valid=1 captured at edge k appears at out when tap_sel=t after t further enabled edges (t+1 enabled edges total); stalled cycles add latency 1:1.
- tap_sel change mid-flight: output switches the same cycle to the newly selected stage; entries are not moved or duplicated; entries beyond the tap continue to shift and are counted until they leave stage DEPTH-1.
- busy = (count != 0), combinational from count register.
- DEPTH=1: tap_sel ignored (sel=0), single register stage.
- No X propagation: all stage data registers reset; invalid bubbles carry data 0.

Decomposition:
- Shared package x_mult_pkg: clog2-based width helper constants (TAPW/CNTW derivation), DLY_DEPTH_DEFAULT=3.
- One sub-module natural: x_mult_dly_stage — one {valid, WIDTH data} register with clk, clrn (async active-low), ena, flush; generate DEPTH instances in a chain. Count, tap mux and busy live in the top.

Test Plan:
- Reset: WIDTH=8, DEPTH=4, drive clrn=0 mid-stream with 3 valid entries -> out_valid=0, out_data=0x00, count=0, busy=0 immediately, no clock needed.
- Basic delay: tap_sel=2, ena=1, push 0xA1,0xB2,0xC3 valid on consecutive edges -> 0xA1 appears at out after 2 further edges, then 0xB2, 0xC3; count peaks 3; after 4 idle edges count=0, busy=0.
- Stall: tap_sel=0, push 0x55, hold ena=0 for 5 cycles with in_valid=1,in_data=0x66 -> out stays 0x55, count=1, 0x66 never captured; ena=1 resumes shifting.
- Flush vs ena: 4 valid entries (count=4), assert flush=1 and ena=1 with in_valid=1,in_data=0x77 -> next edge count=0, all out_valid=0 for every tap, 0x77 not captured.
- Full steady stream: DEPTH=4, in_valid=1 every edge -> count saturates at 4 and stays 4 (enter+exit same edge); out sequence at tap 3 = input delayed 4 edges.
- Tap change + clamp: DEPTH=3 (TAPW=2), entries 0x10,0x20,0x30 in stages 0..2; tap_sel 0->2 shows 0x10 then 0x30 same cycle; tap_sel=3 -> clamps, shows 0x30.
